// File: rtl/wb_mem_slv_if.sv
// Wishbone classic bus between one master and wb_mem_slv; member names follow the slave's view.
// Latency: none (wires only).
// Backpressure: the slave stalls by withholding ack_o/err_o/rty_o; the master holds cyc/stb until one arrives.
interface wb_mem_slv_if #(
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic [31:0]   adr_i;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_i;
    logic          we_i;
    logic          cyc_i;
    logic          stb_i;
    logic          ack_o;
    logic          err_o;
    logic          rty_o;

    modport master (
        output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o, rty_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/wb_mem_slv.sv
// Wishbone slave memory with byte lanes, wait states, retry/error injection and an ack counter.
// Latency: ack WAIT_CYC+1 cycles after the first sampled request; err/rty one cycle after it.
// Backpressure: the master is held off by delayed ack or by rty; each transfer takes at least 2 cycles
// unless WB_MEM_SLV_BURST_EN is defined, which lets a held request be acked on back-to-back cycles.
module wb_mem_slv #(
    parameter int          AW       = 14,
    parameter int          DW       = 32,
    parameter int          WAIT_CYC = 0,
    parameter int          RTY_N    = 0,
    parameter logic [31:0] ERR_ADR  = 32'h0,
    parameter logic [31:0] ERR_MSK  = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_mem_slv_if.slave        bus,
    input  logic               ack_cnt_clr_i,
    output logic [31:0]        ack_cnt_o
);
    localparam int          SW      = DW / 8;
    localparam int          OFS     = $clog2(SW);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYC - 1);
    localparam logic [2:0]  RTY_LIM = 3'(RTY_N);
    localparam bit          ERR_EN  = (ERR_MSK != 32'h0);

    typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    logic [2:0]    rty_cnt, rty_cnt_nxt;
    logic          ack_nxt, err_nxt, rty_nxt;
    logic          acc;
    logic          req, err_hit, rty_pend;
    logic [AW-1:0] idx;
    logic [DW-1:0] sel_mask;
    logic [DW-1:0] mem [DEPTH];

    assign req      = bus.cyc_i & bus.stb_i;
    assign err_hit  = ERR_EN && ((bus.adr_i & ERR_MSK) == ERR_ADR);
    // Retry counter only climbs while below the limit and clears on ack, so equality means "done retrying".
    assign rty_pend = (rty_cnt != RTY_LIM);
    assign idx      = bus.adr_i[AW+OFS-1:OFS];

    // Expand byte-lane selects into a bit mask for read data.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < SW; i++) begin
            sel_mask[8*i +: 8] = {8{bus.sel_i[i]}};
        end
    end

    // Next-state and termination decode; acc marks the edge on which the memory is accessed.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rty_cnt_nxt  = rty_cnt;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;
        rty_nxt      = 1'b0;
        acc          = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = TERM;
                    if (err_hit) begin
                        err_nxt = 1'b1;
                    end else if (rty_pend) begin
                        rty_nxt     = 1'b1;
                        rty_cnt_nxt = rty_cnt + 3'd1;
                    end else if (WAIT_CYC == 0) begin
                        ack_nxt     = 1'b1;
                        acc         = 1'b1;
                        rty_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = WAIT_LD;
                        state_nxt    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt   = TERM;
                    ack_nxt     = 1'b1;
                    acc         = 1'b1;
                    rty_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            TERM: begin
                state_nxt = IDLE;
`ifdef WB_MEM_SLV_BURST_EN
                // A held request right after an ack is the next burst beat: no wait states.
                if (bus.ack_o && req && !err_hit && !rty_pend) begin
                    state_nxt   = TERM;
                    ack_nxt     = 1'b1;
                    acc         = 1'b1;
                    rty_cnt_nxt = '0;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, registered terminations and read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rty_cnt   <= '0;
            bus.ack_o <= 1'b0;
            bus.err_o <= 1'b0;
            bus.rty_o <= 1'b0;
            bus.dat_o <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            rty_cnt   <= rty_cnt_nxt;
            bus.ack_o <= ack_nxt;
            bus.err_o <= err_nxt;
            bus.rty_o <= rty_nxt;
            if (acc && !bus.we_i) begin
                bus.dat_o <= mem[idx] & sel_mask;
            end
        end
    end

    // Count cycles with ack high; clear wins over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_cnt_o <= '0;
        end else if (ack_cnt_clr_i) begin
            ack_cnt_o <= '0;
        end else if (bus.ack_o) begin
            ack_cnt_o <= ack_cnt_o + 32'd1;
        end
    end

    // Byte-masked memory write on the acking edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (acc && bus.we_i) begin
            for (int i = 0; i < SW; i++) begin
                if (bus.sel_i[i]) begin
                    mem[idx][8*i +: 8] <= bus.dat_i[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_mem_slv.sv
// Bench for wb_mem_slv: two instances (no-wait with error window; wait+retry) against a transaction-level model.
// Latency: each transfer is checked for termination type, cycle latency, read data and ack count.
// Backpressure: retries are replayed by the bench until ack, as a Wishbone master would.
module tb_wb_mem_slv;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_mem_slv_if #(.DW(32)) bus0 ();
    wb_mem_slv_if #(.DW(32)) bus1 ();

    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [1:0]  clr;
    logic [31:0] cnt  [2];
    logic [2:0]  term [2];
    logic [31:0] rdat [2];

    assign bus0.adr_i = adr;  assign bus1.adr_i = adr;
    assign bus0.dat_i = wdat; assign bus1.dat_i = wdat;
    assign bus0.sel_i = sel;  assign bus1.sel_i = sel;
    assign bus0.we_i  = we;   assign bus1.we_i  = we;
    assign bus0.cyc_i = cyc[0]; assign bus1.cyc_i = cyc[1];
    assign bus0.stb_i = stb[0]; assign bus1.stb_i = stb[1];
    assign term[0] = {bus0.err_o, bus0.rty_o, bus0.ack_o};
    assign term[1] = {bus1.err_o, bus1.rty_o, bus1.ack_o};
    assign rdat[0] = bus0.dat_o;
    assign rdat[1] = bus1.dat_o;

    wb_mem_slv #(.AW(AW), .DW(32), .WAIT_CYC(0), .RTY_N(0),
                 .ERR_ADR(32'hB000_0000), .ERR_MSK(32'hF000_0000)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0),
        .ack_cnt_clr_i(clr[0]), .ack_cnt_o(cnt[0]));

    wb_mem_slv #(.AW(AW), .DW(32), .WAIT_CYC(3), .RTY_N(2),
                 .ERR_ADR(32'h0), .ERR_MSK(32'h0)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1),
        .ack_cnt_clr_i(clr[1]), .ack_cnt_o(cnt[1]));

    // Reference model: per-instance configuration, memory image, and bus-visible counters.
    int          wait_c  [2] = '{0, 3};
    int          rty_n   [2] = '{0, 2};
    logic [31:0] err_adr [2] = '{32'hB000_0000, 32'h0};
    logic [31:0] err_msk [2] = '{32'hF000_0000, 32'h0};
    logic [31:0] mdl_mem [2][DEPTH];
    logic [31:0] mdl_dat [2];
    logic [31:0] mdl_cnt [2];
    int          mdl_rty [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus attempt: hold the request until any termination (bounded), then release for one cycle.
    task automatic attempt(input int d, input logic [31:0] a, input bit w, input logic [31:0] dd,
                           input logic [3:0] s, input bit clr_ack, output logic [2:0] kind, output int lat);
        adr = a; we = w; wdat = dd; sel = s;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        kind = 3'b000; lat = 0;
        for (int i = 1; i <= 40 && kind == 3'b000; i++) begin
            @(posedge clk); #1;
            if (term[d] != 3'b000) begin
                kind = term[d];
                lat  = i;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        if (kind == 3'b001 && clr_ack) clr[d] = 1'b1;
        @(posedge clk); #1;
        clr[d] = 1'b0;
        check("term_drop", term[d], 3'b000);
    endtask

    task automatic burn_retries(input int d);
        logic [2:0] kind;
        int lat;
        while (mdl_rty[d] > 0) begin
            attempt(d, 32'h0, 1'b0, 32'h0, 4'hF, 1'b0, kind, lat);
            check("rty_kind", kind, 3'b010);
            check("rty_lat", lat, 1);
            mdl_rty[d]--;
        end
    endtask

    // Complete transfer as the model sees it: error, or RTY_N retries then an ack after WAIT_CYC+1 cycles.
    task automatic xfer(input int d, input logic [31:0] a, input bit w, input logic [31:0] dd,
                        input logic [3:0] s, input bit clr_ack);
        logic [2:0]  kind;
        int          lat;
        int          idx;
        logic [31:0] exp;
        idx = int'(a[AW+1:2]);
        if (err_msk[d] != 32'h0 && (a & err_msk[d]) == err_adr[d]) begin
            attempt(d, a, w, dd, s, clr_ack, kind, lat);
            check("err_kind", kind, 3'b100);
            check("err_lat", lat, 1);
        end else begin
            burn_retries(d);
            attempt(d, a, w, dd, s, clr_ack, kind, lat);
            check("ack_kind", kind, 3'b001);
            check("ack_lat", lat, wait_c[d] + 1);
            mdl_rty[d] = rty_n[d];
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl_mem[d][idx][8*b +: 8] = dd[8*b +: 8];
            end else begin
                exp = '0;
                for (int b = 0; b < 4; b++)
                    if (s[b]) exp[8*b +: 8] = mdl_mem[d][idx][8*b +: 8];
                mdl_dat[d] = exp;
            end
            mdl_cnt[d] = clr_ack ? 32'd0 : mdl_cnt[d] + 32'd1;
        end
        check("dat_o", rdat[d], mdl_dat[d]);
        check("ack_cnt", cnt[d], mdl_cnt[d]);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_cnt[d] = '0;
            mdl_dat[d] = '0;
            mdl_rty[d] = rty_n[d];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] old;
        int          n;
        rst = 1'b1; cyc = '0; stb = '0; clr = '0;
        adr = '0; wdat = '0; sel = '0; we = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_term", term[d], 3'b000);
            check("rst_dat", rdat[d], 32'h0);
            check("rst_cnt", cnt[d], 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write/read through an aliased address.
        xfer(0, 32'h0002_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
        xfer(0, 32'h0002_0010, 1'b0, 32'h0, 4'hF, 1'b0);
        check("tp_beef", rdat[0], 32'hDEAD_BEEF);
        check("tp_cnt2", cnt[0], 32'd2);

        // Byte lanes.
        xfer(0, 32'h0000_0024, 1'b1, 32'h1122_3344, 4'hF, 1'b0);
        xfer(0, 32'h0000_0024, 1'b1, 32'hAABB_CCDD, 4'h5, 1'b0);
        xfer(0, 32'h0000_0024, 1'b0, 32'h0, 4'hF, 1'b0);
        check("tp_lanes", rdat[0], 32'h11BB_33DD);

        // Fill both memories so every later read has a known model value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                xfer(d, 32'(i * 4), 1'b1, $urandom, 4'hF, 1'b0);

        // Error window: no write, no count change.
        xfer(0, 32'hB000_0020, 1'b1, 32'h5555_AAAA, 4'hF, 1'b0);
        xfer(0, 32'h0000_0020, 1'b0, 32'h0, 4'hF, 1'b0);

        // Strobe without cycle is not a request.
        stb[0] = 1'b1; n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (term[0] != 3'b000) n++;
        end
        stb[0] = 1'b0;
        check("nocyc_term", n, 0);

        // Abort mid-wait: no termination, no write, retries stay consumed.
        burn_retries(1);
        old = mdl_mem[1][5];
        adr = 32'h14; we = 1'b1; wdat = ~old; sel = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1; n = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (term[1] != 3'b000) n++;
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
        if (term[1] != 3'b000) n++;
        check("abort_term", n, 0);
        xfer(1, 32'h14, 1'b0, 32'h0, 4'hF, 1'b0);
        check("abort_mem", rdat[1], old);

        // Clear coincident with ack wins.
        xfer(0, 32'h8, 1'b0, 32'h0, 4'hF, 1'b1);
        check("clr_cnt", cnt[0], 32'd0);

        // Randomised traffic on both instances.
        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            xfer(k % 2, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0));
        end

`ifdef WB_MEM_SLV_BURST_EN
        // Held strobe: one ack per cycle, address advanced by the bench after each ack.
        adr = 32'h40; we = 1'b0; sel = 4'hF;
        cyc[0] = 1'b1; stb[0] = 1'b1; n = 0;
        for (int i = 1; i <= 20 && n < 4; i++) begin
            @(posedge clk); #1;
            if (term[0] == 3'b001) begin
                check("burst_lat", i, n + 1);
                check("burst_dat", rdat[0], mdl_mem[0][16 + n]);
                mdl_dat[0] = mdl_mem[0][16 + n];
                n++;
                adr = 32'h40 + 32'(4 * n);
            end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
        check("burst_beats", n, 4);
        mdl_cnt[0] = mdl_cnt[0] + 32'd4;
        check("burst_cnt", cnt[0], mdl_cnt[0]);
`endif

        // Asynchronous reset in the middle of a wait.
        xfer(1, 32'h30, 1'b0, 32'h0, 4'hF, 1'b0);
        burn_retries(1);
        adr = 32'h30; we = 1'b0; sel = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("arst_term", term[d], 3'b000);
            check("arst_dat", rdat[d], 32'h0);
            check("arst_cnt", cnt[d], 32'h0);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        xfer(1, 32'h30, 1'b0, 32'h0, 4'hF, 1'b0);
        xfer(0, 32'h0002_0010, 1'b0, 32'h0, 4'hF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
